// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared definitions for the 8-point FFT subsystem: transform
//               size, sample width, frame-controller state encoding and a
//               3-bit index reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N  = 8;
  localparam int FFT_DW = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Mirror a 3-bit index: b2 b1 b0 -> b0 b1 b2.
  function automatic logic [2:0] bitrev3(input logic [2:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft8_frame_buf
// Description : FFT_N x DW sample register file. One write port, all entries
//               presented in parallel as a packed vector (entry k at
//               rdata[DW*k +: DW]).
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset, clears all entries
//               we     - write enable
//               waddr  - entry written when we is high
//               wdata  - data written
//               rdata  - packed parallel read of every entry
// Revision    : 1.0 - initial release
// ============================================================================
module fft8_frame_buf
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [2:0]          waddr,
  input  logic [DW-1:0]       wdata,
  output logic [FFT_N*DW-1:0] rdata
);

  for (genvar e = 0; e < FFT_N; e++) begin : g_entry
    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (we && (waddr == 3'(e))) begin
        r_q <= wdata;
      end
    end

    assign rdata[e*DW +: DW] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/fft8_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft8_frame_ctrl
// Description : Frame sequencer for the combinational fft8 core. Gathers 8
//               serial samples into a buffer that drives the core inputs,
//               waits SETTLE_CYCLES, captures the 8 complex bins and streams
//               them out one per handshake.
// Build macro : FFT8_FRAME_CTRL_BITREV_EN - when defined, bins are emitted in
//               bit-reversed order (0,4,2,6,1,5,3,7); otherwise natural order.
// Ports       : clk, rst_n         - clock, async active-low reset
//               s_data/s_valid/s_ready  - sample input stream
//               fft_a              - packed core inputs, A_k = fft_a[DW*k +: DW]
//               fft_xr/fft_xi      - packed core outputs, same packing
//               m_re/m_im/m_idx/m_valid/m_ready/m_last - bin output stream
//               busy               - high outside FILL
//               frame_cnt          - frames fully drained (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fft8_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DW            = FFT_DW,
  parameter int SETTLE_CYCLES = 2,
  parameter int FCNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [FFT_N*DW-1:0] fft_a,
  input  logic [FFT_N*DW-1:0] fft_xr,
  input  logic [FFT_N*DW-1:0] fft_xi,
  output logic [DW-1:0]       m_re,
  output logic [DW-1:0]       m_im,
  output logic [2:0]          m_idx,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic [FCNT_W-1:0]   frame_cnt
);

  // The counter is loaded with SETTLE_CYCLES-1 so that the capture edge lands
  // exactly SETTLE_CYCLES edges after the edge accepting the last sample.
  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_wr_ptr;
  logic [2:0]          r_rd_ptr;
  logic [3:0]          r_settle_cnt;
  logic [FFT_N*DW-1:0] r_cap_re;
  logic [FFT_N*DW-1:0] r_cap_im;
  logic [FCNT_W-1:0]   r_frame_cnt;

  logic                w_s_fire;
  logic                w_m_fire;
  logic [2:0]          w_order;

  // --------------------------------------------------------------------------
  // Sample buffer; its parallel read is the core input bus, so the core sees
  // a stable frame for the whole of SETTLE.
  // --------------------------------------------------------------------------
  fft8_frame_buf #(
    .DW (DW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_s_fire),
    .waddr (r_wr_ptr),
    .wdata (s_data),
    .rdata (fft_a)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      FILL: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && (r_wr_ptr == 3'd7)) begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == 4'd0) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (m_ready && (r_rd_ptr == 3'd7)) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  assign w_s_fire = s_valid && s_ready;
  assign w_m_fire = m_valid && m_ready;

  // --------------------------------------------------------------------------
  // Pointers, settle counter, capture registers, frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= 3'd0;
      r_rd_ptr     <= 3'd0;
      r_settle_cnt <= 4'd0;
      r_cap_re     <= '0;
      r_cap_im     <= '0;
      r_frame_cnt  <= '0;
    end else begin
      // Write pointer wraps 7 -> 0 on its own when the frame completes.
      if (w_s_fire) begin
        r_wr_ptr <= r_wr_ptr + 3'd1;
        if (r_wr_ptr == 3'd7) begin
          r_settle_cnt <= C_SETTLE_LOAD;
        end
      end

      if (r_state == SETTLE) begin
        if (r_settle_cnt == 4'd0) begin
          r_cap_re <= fft_xr;
          r_cap_im <= fft_xi;
          r_rd_ptr <= 3'd0;
        end else begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
        end
      end

      if (w_m_fire) begin
        r_rd_ptr <= r_rd_ptr + 3'd1;
        if (r_rd_ptr == 3'd7) begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output selection. Everything below depends only on registers, so the bin
  // presented stays put while the downstream stalls.
  // --------------------------------------------------------------------------
`ifdef FFT8_FRAME_CTRL_BITREV_EN
  assign w_order = bitrev3(r_rd_ptr);
`else
  assign w_order = r_rd_ptr;
`endif

  assign m_re      = m_valid ? r_cap_re[w_order*DW +: DW] : '0;
  assign m_im      = m_valid ? r_cap_im[w_order*DW +: DW] : '0;
  assign m_idx     = m_valid ? w_order : 3'd0;
  // The last emitted bin is rd_ptr 7 in either order (bitrev3(7) == 7).
  assign m_last    = m_valid && (r_rd_ptr == 3'd7);
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft8_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fft8_frame_ctrl
// Description : Self-checking bench for fft8_frame_ctrl. Three instances with
//               SETTLE_CYCLES = 2, 1, 15, each with a core stub
//               Xr_k = A_k + k, Xi_k = ~A_k. One instance is active at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft8_frame_ctrl;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] re;
    logic [7:0] im;
    logic       last;
  } bin_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  int         sel = 0;
  bit         rnd_mode = 1'b0;
  logic [7:0] lfsr = 8'hA5;

  logic        s_ready_a [NDUT];
  logic [63:0] fa        [NDUT];
  logic [7:0]  mre       [NDUT];
  logic [7:0]  mim       [NDUT];
  logic [2:0]  midx      [NDUT];
  logic        mv        [NDUT];
  logic        ml        [NDUT];
  logic        busy_a    [NDUT];
  logic [15:0] fc        [NDUT];

  int   checks = 0;
  int   failures = 0;
  int   hs_cnt = 0;
  bin_t q[$];

  logic [7:0] f1 [8] = '{8'd120, 8'd130, 8'd0, 8'd110, 8'd0, 8'd150, 8'd200, 8'd0};
  logic [7:0] f2 [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd250, 8'd251, 8'd252, 8'd255};
  logic [7:0] f3 [8] = '{8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102, 8'd119, 8'd136};
  logic [7:0] f4 [8] = '{8'd99, 8'd0, 8'd255, 8'd128, 8'd127, 8'd64, 8'd9, 8'd200};

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    localparam int SC = (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    logic [63:0] xr;
    logic [63:0] xi;
    logic        svi;

    assign svi = s_valid && (sel == i);

    always_comb begin
      xr = '0;
      xi = '0;
      for (int k = 0; k < 8; k++) begin
        xr[k*8 +: 8] = fa[i][k*8 +: 8] + 8'(k);
        xi[k*8 +: 8] = ~fa[i][k*8 +: 8];
      end
    end

    fft8_frame_ctrl #(
      .DW            (8),
      .SETTLE_CYCLES (SC),
      .FCNT_W        (16)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (svi),
      .s_ready   (s_ready_a[i]),
      .fft_a     (fa[i]),
      .fft_xr    (xr),
      .fft_xi    (xi),
      .m_re      (mre[i]),
      .m_im      (mim[i]),
      .m_idx     (midx[i]),
      .m_valid   (mv[i]),
      .m_ready   (m_ready),
      .m_last    (ml[i]),
      .busy      (busy_a[i]),
      .frame_cnt (fc[i])
    );
  end

  function automatic int sc_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic logic [2:0] tb_order(input int j);
    logic [2:0] t;
    t = 3'(j);
`ifdef FFT8_FRAME_CTRL_BITREV_EN
    return {t[0], t[1], t[2]};
`else
    return t;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream ready: constant 1, or an LFSR pattern for stall testing.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
        lfsr    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        m_ready = lfsr[0];
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: pops one expected bin per handshake; checks stalled outputs hold.
  bit   prev_stall = 1'b0;
  bin_t held;
  always @(negedge clk) begin
    bin_t cur;
    bin_t e;
    cur = {midx[sel], mre[sel], mim[sel], ml[sel]};
    if (rst_n && mv[sel]) begin
      if (prev_stall) begin
        checks++;
        if (cur !== held) begin
          failures++;
          $display("FAIL stall_hold actual=%h required=%h", cur, held);
        end
      end
      if (m_ready) begin
        hs_cnt++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bin actual=%h required=none", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL bin actual(idx,re,im,last)=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                     cur.idx, cur.re, cur.im, cur.last, e.idx, e.re, e.im, e.last);
          end
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        held       = cur;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_sample(input logic [7:0] v, output bit ok);
    bit hs;
    s_data  = v;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int t = 0; t < 300; t++) begin
      hs = s_ready_a[sel];
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d[8], input bit junk);
    bit          ok;
    int          n;
    int          hs0;
    logic [63:0] packed_a;
    hs0 = hs_cnt;
    for (int j = 0; j < 8; j++) begin
      send_sample(d[j], ok);
      if (!ok) begin
        check("sample_accept_timeout", 64'd0, 64'd1);
        return;
      end
    end
    for (int j = 0; j < 8; j++) begin
      logic [2:0] k;
      k = tb_order(j);
      q.push_back({k, d[k] + 8'(k), ~d[k], (j == 7)});
      packed_a[j*8 +: 8] = d[j];
    end
    check("settle_s_ready", {63'd0, s_ready_a[sel]}, 64'd0);
    check("fft_a", fa[sel], packed_a);
    n = 0;
    while (!mv[sel] && n < 100) begin
      if (junk) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(sc_of(sel)));
    n = 0;
    while (busy_a[sel] && n < 2000) begin
      if (junk) begin
        s_valid = 1'b1;
        s_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    check("drain_done", {63'd0, busy_a[sel]}, 64'd0);
    check("fill_s_ready", {63'd0, s_ready_a[sel]}, 64'd1);
    check("bins_per_frame", 64'(hs_cnt - hs0), 64'd8);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {63'd0, s_ready_a[0]}, 64'd1);
    check("rst_m_valid", {63'd0, mv[0]}, 64'd0);
    check("rst_busy", {63'd0, busy_a[0]}, 64'd0);
    check("rst_frame_cnt", 64'(fc[0]), 64'd0);
    check("rst_fft_a", fa[0], 64'd0);
    check("rst_m_out", {35'd0, mre[0], mim[0], midx[0], ml[0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, continuous ready.
    sel = 0;
    send_frame(f1, 1'b0);
    check("frame_cnt_1", 64'(fc[0]), 64'd1);

    // Random back-pressure during DRAIN.
    rnd_mode = 1'b1;
    send_frame(f2, 1'b0);
    rnd_mode = 1'b0;
    check("frame_cnt_2", 64'(fc[0]), 64'd2);

    // s_valid held with changing data through SETTLE/DRAIN.
    send_frame(f3, 1'b1);
    send_frame(f4, 1'b0);
    check("frame_cnt_4", 64'(fc[0]), 64'd4);

    // Reset after 5 samples, then a clean frame.
    for (int j = 0; j < 5; j++) begin
      send_sample(f1[j], ok);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_frame_cnt", 64'(fc[0]), 64'd0);
    check("midrst_busy", {63'd0, busy_a[0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(f2, 1'b0);
    check("post_rst_frame_cnt", 64'(fc[0]), 64'd1);

    // Back-to-back frames at SETTLE_CYCLES = 1 and 15.
    for (int d = 1; d < NDUT; d++) begin
      sel = d;
      @(posedge clk);
      #1;
      send_frame(f1, 1'b0);
      send_frame(f3, 1'b0);
      check("b2b_frame_cnt", 64'(fc[d]), 64'd2);
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Sequencer for the combinational 8-point FFT core (fft8); instantiated alongside it in the FFT subsystem.
- Collects a frame of 8 serial 8-bit samples from a valid/ready stream into a buffer and drives them in parallel onto the core inputs.
- Waits a programmable settle time, captures the 8 real and 8 imaginary outputs, then streams the bins out one per handshake.

Parameters:
- DW, 8, sample and bin width; must match the fft8 core.
- SETTLE_CYCLES, 2, cycles between driving the inputs and capturing the outputs; legal range 1..15.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DW  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  controller accepts a sample.
- fft_a  out  8*DW  core inputs; A_k = fft_a[DW*k +: DW].
- fft_xr  in  8*DW  core real outputs; Xr_k at the same packing.
- fft_xi  in  8*DW  core imaginary outputs; Xi_k at the same packing.
- m_re  out  DW  output bin, real part.
- m_im  out  DW  output bin, imaginary part.
- m_idx  out  3  bin index k of the current output.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accepts the output.
- m_last  out  1  high with the 8th bin of a frame.
- busy  out  1  high in any state other than FILL.
- frame_cnt  out  FCNT_W  number of frames fully drained; wraps.

Behaviour:
- Reset (async assert, sync release): state=FILL, wr_ptr=0, sample buffer=0, capture registers=0, settle counter=0, rd_ptr=0. All outputs are 0, except s_ready=1 once FILL is entered.
- FILL:
  - s_ready=1. On s_valid&&s_ready, buf[wr_ptr]<=s_data and wr_ptr increments.
  - Accepting the sample at wr_ptr=7 moves to SETTLE, sets wr_ptr=0 and loads the settle counter with SETTLE_CYCLES-1.
- SETTLE:
  - s_ready=0, busy=1. fft_a is always driven from buf, so the core inputs are stable for the whole of SETTLE.
  - The counter decrements. At 0, the next edge latches fft_xr/fft_xi into the capture registers and moves to DRAIN with rd_ptr=0.
  - Input-to-capture latency: SETTLE_CYCLES cycles after the edge that accepted sample 7.
- DRAIN:
  - m_valid=1. m_re/m_im/m_idx come from the capture registers at order(rd_ptr); m_last=(rd_ptr==7). Outputs are registered muxes and must not change while m_valid&&!m_ready.
  - Each m_valid&&m_ready increments rd_ptr.
  - The handshake at rd_ptr=7 increments frame_cnt and returns to FILL, where s_ready=1 on the next cycle.
- Default order is natural: order(i)=i.
- Back-pressure:
  - An indefinitely low m_ready holds DRAIN.
  - s_valid outside FILL is ignored; no sample is consumed because s_ready=0.
- The buffer is not cleared between frames. Every frame overwrites all 8 entries before use.
- frame_cnt wraps from all-ones to 0.
- Reset mid-frame discards partial samples and any undrained bins. frame_cnt does not count the interrupted frame.
- No arithmetic is done in this block. Values pass through bit-exact, with the core's DW-bit wrap semantics.

Optional Feature:
- Macro: FFT8_FRAME_CTRL_BITREV_EN.
- Defined: DRAIN emits bins in bit-reversed order 0,4,2,6,1,5,3,7. m_idx carries the true bin index k, and m_last still marks the 8th emitted bin (k=7).
- Undefined: natural order 0..7.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=8 and FFT_DW=8;
  - the state enum {FILL, SETTLE, DRAIN};
  - a bit-reverse function for 3-bit indices.
- A single sub-module, fft8_frame_buf, is natural. It holds the 8xDW sample register file with write port and packed parallel read.
- The FSM, settle counter, capture registers and output mux stay in the top level.

Test Plan:
All scenarios use a bench stub for the core: Xr_k=A_k+k, Xi_k=~A_k (mod 256).
- Reset then stream 120,130,0,110,0,150,200,0 with m_ready=1:
  - the 8th sample is followed by SETTLE_CYCLES=2 cycles with s_ready=0;
  - then bins stream out, for example (re,im) (120,135) at k=0, (131,125) at k=1, (7,255) at k=7;
  - m_last is high on k=7 and frame_cnt=1.
- Toggle m_ready pseudo-randomly during DRAIN: m_re/m_im/m_idx are held while stalled, no bin is dropped or repeated, and 8 handshakes complete.
- Hold s_valid high during SETTLE/DRAIN with changing data: no extra samples are taken, and the next frame's first bin reflects only the first sample accepted in FILL.
- Assert rst_n low after 5 samples, release, then send a full frame: outputs match the new frame only and frame_cnt=1.
- With FFT8_FRAME_CTRL_BITREV_EN defined, same frame as the first scenario: m_idx sequence is 0,4,2,6,1,5,3,7 with matching bins, and m_last is on idx 7.
- Back-to-back frames with SETTLE_CYCLES=1 and SETTLE_CYCLES=15: latency matches the parameter, and frame_cnt=2 after two frames.
